// File: rtl/memory_slot_controller.sv
// memory_slot_controller: GET/PUT/DEL sequencer for a bank of key/value slot arrays.
// Optional SCRUB_ON_DELETE_EN: a DEL hit also writes zeros into the freed slot.
module memory_slot_controller #(
  parameter int NUM_ENTRIES = 8,
  parameter int KEY_WIDTH   = 32,
  parameter int VALUE_WIDTH = 64,
  localparam int IW = $clog2(NUM_ENTRIES),
  localparam int OW = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [1:0]                     req_op,
  input  logic [KEY_WIDTH-1:0]           req_key,
  input  logic [VALUE_WIDTH-1:0]         req_value,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [1:0]                     rsp_status,
  output logic [VALUE_WIDTH-1:0]         rsp_value,
  output logic [NUM_ENTRIES-1:0]         arr_write_op,
  output logic [NUM_ENTRIES-1:0]         arr_select_op,
  output logic [KEY_WIDTH-1:0]           arr_key_wdata,
  output logic [VALUE_WIDTH-1:0]         arr_val_wdata,
  input  logic [NUM_ENTRIES*KEY_WIDTH-1:0]   arr_key_rdata,
  input  logic [NUM_ENTRIES*VALUE_WIDTH-1:0] arr_val_rdata,
  output logic [OW-1:0]                  occupancy
);
`ifdef SCRUB_ON_DELETE_EN
  localparam bit SCRUB = 1'b1;
`else
  localparam bit SCRUB = 1'b0;
`endif
  localparam logic [1:0] OP_GET = 2'b01, OP_PUT = 2'b10, OP_DEL = 2'b11;
  localparam logic [1:0] ST_OK = 2'b00, ST_MISS = 2'b01, ST_FULL = 2'b10, ST_ERR = 2'b11;
  typedef enum logic [1:0] {IDLE, LOOKUP, EXEC, RESP} state_t;
  state_t                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d, key_wdata_q, key_wdata_d;
  logic [VALUE_WIDTH-1:0] val_q, val_d, val_wdata_q, val_wdata_d, rsp_value_q, rsp_value_d;
  logic [NUM_ENTRIES-1:0] valid_q, valid_d, write_op_q, write_op_d, select_op_q, select_op_d;
  logic [OW-1:0]          occ_q, occ_d;
  logic                   hit_q, hit_d, full_q, full_d, rsp_valid_q, rsp_valid_d, req_ready_q, req_ready_d;
  logic [IW-1:0]          hit_idx_q, hit_idx_d, free_idx_q, free_idx_d, hit_idx, free_idx;
  logic [1:0]             rsp_status_q, rsp_status_d;
  logic                   hit;
  logic [NUM_ENTRIES-1:0] hit_oh, free_oh;
  // Descending scan so the lowest matching / free index wins; invalid slots never match.
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && arr_key_rdata[i*KEY_WIDTH +: KEY_WIDTH] == key_q) begin
        hit = 1'b1;
        hit_idx = IW'(i);
      end
      if (!valid_q[i]) free_idx = IW'(i);
    end
  end
  assign hit_oh  = NUM_ENTRIES'(1) << hit_idx;
  assign free_oh = NUM_ENTRIES'(1) << free_idx;
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    key_d = key_q;
    val_d = val_q;
    valid_d = valid_q;
    occ_d = occ_q;
    hit_d = hit_q;
    full_d = full_q;
    hit_idx_d = hit_idx_q;
    free_idx_d = free_idx_q;
    write_op_d = '0;
    select_op_d = '0;
    key_wdata_d = '0;
    val_wdata_d = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_status_d = rsp_status_q;
    rsp_value_d = rsp_value_q;
    case (state_q)
      IDLE: if (req_valid && req_ready_q) begin
        op_d = req_op;
        key_d = req_key;
        val_d = req_value;
        state_d = LOOKUP;
      end
      // Strobes are computed here and registered so they are driven for exactly the EXEC cycle.
      LOOKUP: begin
        hit_d = hit;
        full_d = &valid_q;
        hit_idx_d = hit_idx;
        free_idx_d = free_idx;
        if (op_q == OP_GET && hit) select_op_d = hit_oh;
        if (op_q == OP_PUT && (hit || !(&valid_q))) begin
          write_op_d = hit ? hit_oh : free_oh;
          select_op_d = hit ? hit_oh : free_oh;
          key_wdata_d = key_q;
          val_wdata_d = val_q;
        end
        if (SCRUB && op_q == OP_DEL && hit) begin
          write_op_d = hit_oh;
          select_op_d = hit_oh;
        end
        state_d = EXEC;
      end
      EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_value_d = '0;
        rsp_status_d = ST_ERR;
        state_d = RESP;
        if (op_q == OP_GET) begin
          rsp_status_d = hit_q ? ST_OK : ST_MISS;
          if (hit_q) rsp_value_d = arr_val_rdata[int'(hit_idx_q)*VALUE_WIDTH +: VALUE_WIDTH];
        end
        if (op_q == OP_PUT) begin
          rsp_status_d = (hit_q || !full_q) ? ST_OK : ST_FULL;
          if (!hit_q && !full_q) begin
            valid_d[free_idx_q] = 1'b1;
            occ_d = occ_q + OW'(1);
          end
        end
        if (op_q == OP_DEL) begin
          rsp_status_d = hit_q ? ST_OK : ST_MISS;
          if (hit_q) begin
            valid_d[hit_idx_q] = 1'b0;
            occ_d = occ_q - OW'(1);
          end
        end
      end
      default: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    req_ready_d = (state_d == IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q <= '0;
      key_q <= '0;
      val_q <= '0;
      valid_q <= '0;
      occ_q <= '0;
      hit_q <= 1'b0;
      full_q <= 1'b0;
      hit_idx_q <= '0;
      free_idx_q <= '0;
      write_op_q <= '0;
      select_op_q <= '0;
      key_wdata_q <= '0;
      val_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_status_q <= '0;
      rsp_value_q <= '0;
      req_ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      key_q <= key_d;
      val_q <= val_d;
      valid_q <= valid_d;
      occ_q <= occ_d;
      hit_q <= hit_d;
      full_q <= full_d;
      hit_idx_q <= hit_idx_d;
      free_idx_q <= free_idx_d;
      write_op_q <= write_op_d;
      select_op_q <= select_op_d;
      key_wdata_q <= key_wdata_d;
      val_wdata_q <= val_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_value_q <= rsp_value_d;
      req_ready_q <= req_ready_d;
    end
  end
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_status = rsp_status_q;
  assign rsp_value = rsp_value_q;
  assign arr_write_op = write_op_q;
  assign arr_select_op = select_op_q;
  assign arr_key_wdata = key_wdata_q;
  assign arr_val_wdata = val_wdata_q;
  assign occupancy = occ_q;
endmodule

// File: tb/tb_memory_slot_controller.sv
// tb_memory_slot_controller: directed + randomized checks of memory_slot_controller against a slot-table model.
module tb_memory_slot_controller;
  localparam int N = 8, KW = 32, VW = 64;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, rsp_ready = 1'b1;
  logic req_ready, rsp_valid;
  logic [1:0] req_op = '0, rsp_status;
  logic [KW-1:0] req_key = '0, arr_key_wdata;
  logic [VW-1:0] req_value = '0, rsp_value, arr_val_wdata;
  logic [N-1:0] arr_write_op, arr_select_op;
  logic [N*KW-1:0] arr_key_rdata;
  logic [N*VW-1:0] arr_val_rdata;
  logic [3:0] occupancy;
  logic [KW-1:0] mem_key [N];
  logic [VW-1:0] mem_val [N];
  bit m_valid [N];
  logic [KW-1:0] m_key [N];
  logic [VW-1:0] m_val [N];
  int checks = 0, failures = 0;

  memory_slot_controller #(.NUM_ENTRIES(N), .KEY_WIDTH(KW), .VALUE_WIDTH(VW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_value(req_value), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_value(rsp_value), .arr_write_op(arr_write_op),
    .arr_select_op(arr_select_op), .arr_key_wdata(arr_key_wdata), .arr_val_wdata(arr_val_wdata),
    .arr_key_rdata(arr_key_rdata), .arr_val_rdata(arr_val_rdata), .occupancy(occupancy));

  always #5 clk = ~clk;

  // Slot register arrays that the controller sequences.
  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (arr_write_op[i]) begin
        mem_key[i] <= arr_key_wdata;
        mem_val[i] <= arr_val_wdata;
      end
  always_comb
    for (int i = 0; i < N; i++) begin
      arr_key_rdata[i*KW +: KW] = mem_key[i];
      arr_val_rdata[i*VW +: VW] = mem_val[i];
    end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_occ();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_valid[i]);
    return c;
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [KW-1:0] key, input logic [VW-1:0] val, input int hold);
    int h = -1, f = -1, slot = -1, waited = 0;
    logic [N-1:0] one = 1, ew = 0, es = 0;
    logic [1:0] est = 2'b11;
    logic [VW-1:0] ev = 0;
    for (int i = 0; i < N; i++) begin
      if (h < 0 && m_valid[i] && m_key[i] == key) h = i;
      if (f < 0 && !m_valid[i]) f = i;
    end
    if (op == 2'b01) begin
      est = (h >= 0) ? 2'b00 : 2'b01;
      if (h >= 0) begin es = one << h; ev = m_val[h]; end
    end else if (op == 2'b10) begin
      slot = (h >= 0) ? h : f;
      est = (slot >= 0) ? 2'b00 : 2'b10;
      if (slot >= 0) begin
        ew = one << slot;
        es = ew;
        m_valid[slot] = 1'b1;
        m_key[slot] = key;
        m_val[slot] = val;
      end
    end else if (op == 2'b11) begin
      est = (h >= 0) ? 2'b00 : 2'b01;
      if (h >= 0) begin
        m_valid[h] = 1'b0;
`ifdef SCRUB_ON_DELETE_EN
        ew = one << h;
        es = ew;
`endif
      end
    end
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 0, 1);
      return;
    end
    rsp_ready = (hold == 0);
    req_valid = 1'b1;
    req_op = op;
    req_key = key;
    req_value = val;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("lookup_rsp_valid", rsp_valid, 0);
    check("lookup_write_op", arr_write_op, 0);
    @(negedge clk);
    check("exec_rsp_valid", rsp_valid, 0);
    check("exec_write_op", arr_write_op, ew);
    check("exec_select_op", arr_select_op, es);
    if (ew != 0) begin
      check("exec_key_wdata", arr_key_wdata, (op == 2'b10) ? key : 0);
      check("exec_val_wdata", arr_val_wdata, (op == 2'b10) ? val : 0);
    end
    @(negedge clk);
    check("resp_rsp_valid", rsp_valid, 1);
    check("resp_status", rsp_status, est);
    check("resp_value", rsp_value, ev);
    check("resp_occupancy", occupancy, model_occ());
    check("resp_req_ready", req_ready, 0);
    for (int k = 1; k < hold; k++) begin
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_status", rsp_status, est);
      check("hold_value", rsp_value, ev);
      check("hold_req_ready", req_ready, 0);
    end
    if (hold > 0) begin
      rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    check("idle_rsp_valid", rsp_valid, 0);
    check("idle_req_ready", req_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_req_ready", req_ready, 0);
    check("reset_occupancy", occupancy, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_req_ready", req_ready, 1);
    // Basic GET/PUT/overwrite.
    do_op(2'b01, 32'h11, 64'h0, 0);
    do_op(2'b10, 32'h11, 64'hAA, 0);
    do_op(2'b01, 32'h11, 64'h0, 0);
    do_op(2'b10, 32'h11, 64'hBB, 0);
    do_op(2'b01, 32'h11, 64'h0, 0);
    // Fill, overflow, free a middle slot, refill it.
    do_op(2'b11, 32'h11, 64'h0, 0);
    for (int k = 1; k <= 8; k++) do_op(2'b10, KW'(k), VW'(k) * 64'h101, 0);
    check("full_occupancy", occupancy, 8);
    do_op(2'b10, 32'd9, 64'h99, 0);
    do_op(2'b11, 32'd3, 64'h0, 0);
    do_op(2'b10, 32'd9, 64'h99, 0);
    check("refill_slot2", m_valid[2] && m_key[2] == 32'd9, 1);
    do_op(2'b11, 32'h77, 64'h0, 0);
    do_op(2'b00, 32'd1, 64'h0, 0);
    do_op(2'b01, 32'd3, 64'h0, 0);
    // Back-pressured response.
    do_op(2'b01, 32'd9, 64'h0, 5);
    // Reset while a PUT is in EXEC.
    for (int i = 0; i < N; i++) do_op(2'b11, KW'(i + 1), 64'h0, 0);
    do_op(2'b11, 32'd9, 64'h0, 0);
    req_valid = 1'b1;
    req_op = 2'b10;
    req_key = 32'h55;
    req_value = 64'h5555;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_exec_write_op", arr_write_op, 0);
    check("rst_exec_select_op", arr_select_op, 0);
    check("rst_exec_key_wdata", arr_key_wdata, 0);
    check("rst_exec_occupancy", occupancy, 0);
    check("rst_exec_rsp_valid", rsp_valid, 0);
    check("rst_exec_status", rsp_status, 0);
    check("rst_exec_value", rsp_value, 0);
    check("rst_exec_req_ready", req_ready, 0);
    repeat (2) @(negedge clk);
    check("rst_hold_write_op", arr_write_op, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_req_ready", req_ready, 1);
    do_op(2'b01, 32'h55, 64'h0, 0);
    // Randomized traffic over a small key space so hits, misses and FULL all occur.
    for (int n = 0; n < 300; n++)
      do_op(2'($urandom_range(0, 3)), KW'($urandom_range(1, 12)), {$urandom, $urandom},
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/memory_slot_controller.md
Name: memory_slot_controller

Overview:
Sequences a bank of NUM_ENTRIES key/value register-array slots for the cache core. It accepts GET/PUT/DEL requests over a valid/ready handshake and tracks slot occupancy with a valid bitmap. It resolves hits by comparing keys across all slots, allocates free slots, and drives one-hot write_op/select_op strobes into the slot register arrays. It returns status and data over a valid/ready response channel.

Parameters:
NUM_ENTRIES, 8, number of key/value slots (≥2)
KEY_WIDTH, 32, key width in bits
VALUE_WIDTH, 64, value width in bits

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  1  request valid
req_ready  output  1  controller can accept a request
req_op  input  2  00 NOP, 01 GET, 10 PUT, 11 DEL
req_key  input  KEY_WIDTH  request key
req_value  input  VALUE_WIDTH  PUT data
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer accepts response
rsp_status  output  2  00 OK, 01 MISS, 10 FULL, 11 ERR
rsp_value  output  VALUE_WIDTH  GET data; 0 otherwise
arr_write_op  output  NUM_ENTRIES  one-hot write strobe per slot
arr_select_op  output  NUM_ENTRIES  one-hot slot select for the current operation
arr_key_wdata  output  KEY_WIDTH  key written to the selected slot
arr_val_wdata  output  VALUE_WIDTH  value written to the selected slot
arr_key_rdata  input  NUM_ENTRIES*KEY_WIDTH  flattened slot key outputs; slot i at [i*KEY_WIDTH +: KEY_WIDTH]
arr_val_rdata  input  NUM_ENTRIES*VALUE_WIDTH  flattened slot value outputs
occupancy  output  $clog2(NUM_ENTRIES+1)  count of valid slots

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset (rst_n low):
  - state = IDLE; valid bitmap = 0; occupancy = 0.
  - rsp_valid = 0, rsp_status = 0, rsp_value = 0.
  - arr_write_op = 0, arr_select_op = 0, wdata = 0.
  - req_ready = 0 while in reset; req_ready = 1 on the first cycle after release.
  - Reset mid-operation discards the in-flight request; no write strobe is issued.
- FSM states: IDLE → LOOKUP → EXEC → RESP → IDLE.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch op, key and value, then go to LOOKUP. req_ready = 0 in every other state.
- LOOKUP (1 cycle):
  - Compare the latched key against every slot whose valid bit is 1.
  - hit_idx = lowest matching index.
  - free_idx = lowest index with valid = 0.
  - Register hit, hit_idx, full (all valid) and free_idx.
- EXEC (1 cycle). Strobes are one-hot and asserted for exactly this cycle.
  - GET hit: select_op[hit_idx] = 1; capture arr_val_rdata slot hit_idx into rsp_value; status OK.
  - GET miss: status MISS, rsp_value 0.
  - PUT hit: write_op and select_op at hit_idx; key and value driven on wdata; status OK; occupancy unchanged.
  - PUT miss, not full: write at free_idx; set its valid bit; occupancy +1; status OK.
  - PUT miss, full: no strobe; status FULL.
  - DEL hit: clear the valid bit; occupancy −1; status OK.
  - DEL miss: status MISS.
  - NOP: status ERR, no strobe.
- RESP:
  - rsp_valid = 1; status and value are held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE.
  - rsp_ready may already be high on entry, giving a single RESP cycle.
- Timing: request handshake to rsp_valid = 3 cycles. Minimum request-to-request interval = 4 cycles.
- A PUT write is visible to a following GET: the array register updates at the end of EXEC, well before the next LOOKUP.
- Keys in invalid slots never match, whatever stale data they hold.
- occupancy saturates within 0..NUM_ENTRIES by construction. A PUT when full never modifies the bitmap.

Optional Feature:
Macro SCRUB_ON_DELETE_EN.
- Defined: a DEL hit also pulses write_op and select_op at hit_idx in EXEC, with arr_key_wdata = 0 and arr_val_wdata = 0, so the freed slot holds zeros.
- Undefined: a DEL hit only clears the valid bit; arr_write_op stays 0 and the slot data is left stale.
- Status, latency and occupancy are identical in both cases.

Test Plan:
1. Reset with rsp_ready=1 → occupancy 0, req_ready=1 after release. GET key 0x11 → MISS, rsp_value 0, rsp_valid exactly 3 cycles after the handshake.
2. PUT 0x11=0xAA → write_op=0b00000001, OK, occupancy 1. GET 0x11 → OK, 0xAA. PUT 0x11=0xBB → strobe again at slot 0, occupancy stays 1. GET → 0xBB.
3. Fill all 8 slots with keys 1..8 → occupancy 8. PUT key 9 → FULL, no strobe. DEL key 3 → OK, occupancy 7. PUT key 9 → written to slot 2.
4. DEL an absent key → MISS. NOP op → ERR. Neither changes the bitmap. Run with and without SCRUB_ON_DELETE_EN: a DEL hit strobes zeros to the slot only when the macro is defined.
5. Hold rsp_ready=0 for 5 cycles → rsp_valid, status and value stay stable and req_ready stays 0. Release → one handshake, then IDLE.
6. Assert rst_n low during EXEC of a PUT → no strobe after the reset edge, bitmap 0, outputs at their reset values.
